clk_div: RTL and testbench

CLK_DIV -- requirements
Module: clk_div

---
 rtl/clk_div.sv | 102 ++++++++++
 tb/tb_clk_div.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Programmable integer clock divider with glitch-free ratio changes applied only at period boundaries.
// Optional lock detector enabled by defining CLK_DIV_LOCK_EN; otherwise locked simply follows reset.
module clk_div #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int LOCK_PERIODS = 2
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_pending,
  output logic             div_ack,
  output logic             div_err,
  output logic             out_clk,
  output logic             rise_tick,
  output logic             locked
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] n_pend;
  logic             started;

  logic             period_start;
  logic             apply;
  logic             accept;
  logic             reject;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] hi_cnt;

  // The first edge after reset always opens a period, regardless of the counter.
  always_comb begin
    period_start = !started || (cnt == n_act - 1'b1);
    apply        = period_start && div_pending;
    accept       = div_load && !div_pending && (div_val >= WIDTH'(2));
    reject       = div_load && !div_pending && (div_val <  WIDTH'(2));
    cnt_inc      = cnt + 1'b1;
    hi_cnt       = n_act - (n_act >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      // NOTE: every flop, including the captured ratio, is reset so a pending load is discarded.
      cnt         <= '0;
      n_act       <= WIDTH'(DEFAULT_DIV);
      n_pend      <= '0;
      started     <= 1'b0;
      out_clk     <= 1'b0;
      rise_tick   <= 1'b0;
      div_ack     <= 1'b0;
      div_err     <= 1'b0;
      div_pending <= 1'b0;
    end else begin
      started   <= 1'b1;
      rise_tick <= period_start;
      div_ack   <= apply;
      div_err   <= reject;

      if (period_start) begin
        cnt     <= '0;
        out_clk <= 1'b1;
        if (apply) n_act <= n_pend;
      end else begin
        cnt     <= cnt_inc;
        out_clk <= (cnt_inc < hi_cnt);
      end

      // apply needs div_pending=1 and accept needs div_pending=0, so they never collide.
      if (apply) begin
        div_pending <= 1'b0;
      end else if (accept) begin
        div_pending <= 1'b1;
        n_pend      <= div_val;
      end
    end
  end

`ifdef CLK_DIV_LOCK_EN
  localparam int LCW = $clog2(LOCK_PERIODS + 2);

  logic [LCW-1:0] lock_cnt;

  // lock_cnt holds the number of periods started; a ratio change restarts at period 1.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (apply) begin
      lock_cnt <= LCW'(1);
      locked   <= 1'b0;
    end else if (period_start && !locked) begin
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LCW'(LOCK_PERIODS)) locked <= 1'b1;
    end
  end
`else
  assign locked = !rst;
`endif

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div (default parameters); expected waveforms are hand-written per-edge strings.
// Lock expectations switch on CLK_DIV_LOCK_EN so the same vectors cover both builds.
module tb_clk_div;

  logic       ref_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] div_val = '0;
  logic       div_load = 1'b0;
  logic       div_pending, div_ack, div_err, out_clk, rise_tick, locked;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div dut (
    .ref_clk     (ref_clk),
    .rst         (rst),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_pending (div_pending),
    .div_ack     (div_ack),
    .div_err     (div_err),
    .out_clk     (out_clk),
    .rise_tick   (rise_tick),
    .locked      (locked)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input string s, input int i);
    return s[i] == "1";
  endfunction

  // Assert reset 1 ns after an edge, check the forced state, release 1 ns after a later edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, " reset state {out,rise,pend,ack,err,lock}"},
          {26'd0, out_clk, rise_tick, div_pending, div_ack, div_err, locked}, 32'd0);
    repeat (2) @(posedge ref_clk);
    #1;
    rst      = 1'b0;
    div_load = 1'b0;
  endtask

  // Runs edges 1..n; loads are presented before edge ld1/ld2 (0 = none).
  // Each edge compares {out,rise,pend,ack,err,lock} 1 ns after the edge.
  task automatic run_seq(input string tag, input int n,
                         input int ld1, input int v1, input int ld2, input int v2,
                         input string e_out, input string e_rise, input string e_pend,
                         input string e_ack, input string e_err, input string e_lock);
    logic [5:0] exp;
    for (int e = 1; e <= n; e++) begin
      div_load = (e == ld1) || (e == ld2);
      div_val  = (e == ld1) ? 8'(v1) : 8'(v2);
      @(posedge ref_clk);
      #1;
      div_load = 1'b0;
`ifdef CLK_DIV_LOCK_EN
      exp = {bit_at(e_out, e-1), bit_at(e_rise, e-1), bit_at(e_pend, e-1),
             bit_at(e_ack, e-1), bit_at(e_err, e-1), bit_at(e_lock, e-1)};
`else
      exp = {bit_at(e_out, e-1), bit_at(e_rise, e-1), bit_at(e_pend, e-1),
             bit_at(e_ack, e-1), bit_at(e_err, e-1), 1'b1};
`endif
      check($sformatf("%s edge %0d {out,rise,pend,ack,err,lock}", tag, e),
            {26'd0, out_clk, rise_tick, div_pending, div_ack, div_err, locked},
            {26'd0, exp});
    end
  endtask

  initial begin
    // Default ratio 4: 1100 repeating, rise at 1,5,9,13, lock from edge 9.
    do_reset("n4");
    run_seq("n4", 13, 0, 0, 0, 0,
            "1100110011001", "1000100010001", "0000000000000",
            "0000000000000", "0000000000000", "0000000011111");

    // Load 5 at edge 2: applied at edge 5, next rise at edge 10; ack restarts lock count.
    do_reset("load5");
    run_seq("load5", 14, 2, 5, 0, 0,
            "11001110011100", "10001000010000", "01110000000000",
            "00001000000000", "00000000000000", "00000000000000");

    // Illegal ratio 1: error pulse only, ratio 4 continues.
    do_reset("err1");
    run_seq("err1", 9, 2, 1, 0, 0,
            "110011001", "100010001", "000000000",
            "000010000" == "" ? "" : "000000000", "010000000", "000000001");

    // Ratio 0 is also illegal.
    do_reset("err0");
    run_seq("err0", 5, 3, 0, 0, 0,
            "11001", "10001", "00000",
            "00000", "00100", "00000");

    // Load 6 at edge 2, load 8 at edge 3 ignored while pending.
    do_reset("load6");
    run_seq("load6", 12, 2, 6, 3, 8,
            "110011100011", "100010000010", "011100000000",
            "000010000000", "000000000000", "000000000000");

    // Load at the ack edge is ignored; load at a period-start edge waits a full period.
    do_reset("ack_ld");
    run_seq("ack_ld", 13, 2, 3, 5, 2,
            "1100110110110", "1000100100100", "0111000000000",
            "0000100000000", "0000000000000", "0000000000000");

    // Lock sequence: ratio 4 locks at 9, load 3 at 10 applied at 13, relock at 19.
    do_reset("lock");
    run_seq("lock", 19, 10, 3, 0, 0,
            "1100110011001101101", "1000100010001001001", "0000000001110000000",
            "0000000000001000000", "0000000000000000000", "0000000011110000001");

    // Reset mid-high-phase with a load pending acts without a clock edge.
    do_reset("async");
    run_seq("async_pre", 2, 2, 7, 0, 0,
            "11", "10", "01", "00", "00", "00");
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_clk", {31'd0, out_clk}, 32'd0);
    check("async reset div_pending", {31'd0, div_pending}, 32'd0);
    check("async reset locked", {31'd0, locked}, 32'd0);
    @(posedge ref_clk);
    #1;
    rst = 1'b0;
    run_seq("async_post", 9, 0, 0, 0, 0,
            "110011001", "100010001", "000000000",
            "000000000", "000000000", "000000001");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
